// File: rtl/gumnut_bus_pkg.sv
// Shared types and constants for the Gumnut memory arbiter.
package gumnut_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } arb_state_e;

    localparam int GNT_INST = 0;
    localparam int GNT_DATA = 1;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 18;

endpackage

// File: rtl/gumnut_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port memory between
// the Gumnut instruction-fetch and data ports.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no access in flight; requests sampled, winner latched
// ST_ACCESS | memory cycle; mem_en on first cycle, counter runs down
// ST_ACK    | one-cycle ack to the granted requester, grant still held
module gumnut_mem_arbiter
    import gumnut_bus_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inst_cyc_i,
    input  logic          inst_stb_i,
    input  logic [AW-1:0] inst_adr_i,
    output logic [DW-1:0] inst_dat_o,
    output logic          inst_ack_o,
    input  logic          data_cyc_i,
    input  logic          data_stb_i,
    input  logic          data_we_i,
    input  logic [AW-1:0] data_adr_i,
    input  logic [DW-1:0] data_dat_i,
    output logic [DW-1:0] data_dat_o,
    output logic          data_ack_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_adr_o,
    output logic [DW-1:0] mem_dat_o,
    input  logic [DW-1:0] mem_dat_i,
    output logic [1:0]    grant_o
);

    localparam int CW = ($clog2(MEM_LAT + 1) < 1) ? 1 : $clog2(MEM_LAT + 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          last_data_q;
    logic [1:0]    grant_q;
    logic [AW-1:0] adr_q;
    logic          we_q;
    logic [DW-1:0] wdat_q;
    logic          en_q;
    logic          inst_ack_q, data_ack_q;
    logic [DW-1:0] inst_dat_q, data_dat_q;

    logic req_inst, req_data;
    logic grant_now, pick_data, done;

    assign req_inst = inst_cyc_i & inst_stb_i;
    assign req_data = data_cyc_i & data_stb_i;
    assign done     = (state_q == ST_ACCESS) && (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        grant_now = 1'b0;
        pick_data = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_inst || req_data) begin
                    grant_now = 1'b1;
                    // On a tie, the requester that did not win last time goes
                    pick_data = req_data & (~req_inst | ~last_data_q);
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: if (cnt_q == '0) state_d = ST_ACK;
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            last_data_q <= 1'b0;
            grant_q     <= '0;
            adr_q       <= '0;
            we_q        <= 1'b0;
            wdat_q      <= '0;
            en_q        <= 1'b0;
            inst_ack_q  <= 1'b0;
            data_ack_q  <= 1'b0;
            inst_dat_q  <= '0;
            data_dat_q  <= '0;
        end else begin
            en_q       <= grant_now;
            inst_ack_q <= done & grant_q[GNT_INST];
            data_ack_q <= done & grant_q[GNT_DATA];
            if (grant_now) begin
                adr_q       <= pick_data ? data_adr_i : inst_adr_i;
                we_q        <= pick_data & data_we_i;
                wdat_q      <= pick_data ? data_dat_i : '0;
                grant_q     <= pick_data ? 2'b10 : 2'b01;
                last_data_q <= pick_data;
                cnt_q       <= CW'(MEM_LAT);
            end else if (state_q == ST_ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (state_q == ST_ACK) grant_q <= '0;
            if (done && grant_q[GNT_INST]) inst_dat_q <= mem_dat_i;
            if (done && grant_q[GNT_DATA] && !we_q) data_dat_q <= mem_dat_i;
        end
    end

    assign mem_en_o   = en_q;
    assign mem_we_o   = we_q & (state_q == ST_ACCESS);
    assign mem_adr_o  = adr_q;
    assign mem_dat_o  = wdat_q;
    assign grant_o    = grant_q;
    assign inst_ack_o = inst_ack_q;
    assign data_ack_o = data_ack_q;
    assign inst_dat_o = inst_dat_q;
    assign data_dat_o = data_dat_q;

endmodule

// File: tb/tb_gumnut_mem_arbiter.sv
// Directed bench for gumnut_mem_arbiter with a behavioural one-cycle BRAM.
module tb_gumnut_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 18;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          inst_cyc_i = 1'b0, inst_stb_i = 1'b0;
    logic [AW-1:0] inst_adr_i = '0;
    logic [DW-1:0] inst_dat_o;
    logic          inst_ack_o;
    logic          data_cyc_i = 1'b0, data_stb_i = 1'b0, data_we_i = 1'b0;
    logic [AW-1:0] data_adr_i = '0;
    logic [DW-1:0] data_dat_i = '0;
    logic [DW-1:0] data_dat_o;
    logic          data_ack_o;
    logic          mem_en_o, mem_we_o;
    logic [AW-1:0] mem_adr_o;
    logic [DW-1:0] mem_dat_o;
    logic [DW-1:0] mem_dat_i = '0;
    logic [1:0]    grant_o;

    logic [DW-1:0] bram [0:(1<<AW)-1];

    int n_assert = 0;
    int n_fail   = 0;

    gumnut_mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .inst_cyc_i(inst_cyc_i), .inst_stb_i(inst_stb_i), .inst_adr_i(inst_adr_i),
        .inst_dat_o(inst_dat_o), .inst_ack_o(inst_ack_o),
        .data_cyc_i(data_cyc_i), .data_stb_i(data_stb_i), .data_we_i(data_we_i),
        .data_adr_i(data_adr_i), .data_dat_i(data_dat_i),
        .data_dat_o(data_dat_o), .data_ack_o(data_ack_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
        .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i), .grant_o(grant_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (mem_en_o) begin
            if (mem_we_o) bram[mem_adr_o] <= mem_dat_o;
            else          mem_dat_i <= bram[mem_adr_o];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic set_inst(input logic r, input logic [AW-1:0] a);
        inst_cyc_i = r; inst_stb_i = r; inst_adr_i = a;
    endtask

    task automatic set_data(input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        data_cyc_i = r; data_stb_i = r; data_we_i = w; data_adr_i = a; data_dat_i = d;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) bram[i] = '0;
        bram[12'h010] = 18'h2ABCD;
        bram[12'h020] = 18'h12345;

        // reset values
        step(2);
        chk("rst_grant", 32'(grant_o), 0);
        chk("rst_en", 32'(mem_en_o), 0);
        chk("rst_inst_dat", 32'(inst_dat_o), 0);
        rst_ni = 1'b1;
        step(1);

        // inst read of 0x010
        set_inst(1'b1, 12'h010);
        chk("t1_c0_grant", 32'(grant_o), 0);
        step(1);
        chk("t1_c1_en", 32'(mem_en_o), 1);
        chk("t1_c1_adr", 32'(mem_adr_o), 32'h010);
        chk("t1_c1_we", 32'(mem_we_o), 0);
        chk("t1_c1_grant", 32'(grant_o), 1);
        step(1);
        chk("t1_c2_en", 32'(mem_en_o), 0);
        chk("t1_c2_ack", 32'(inst_ack_o), 0);
        chk("t1_c2_grant", 32'(grant_o), 1);
        step(1);
        chk("t1_c3_ack", 32'(inst_ack_o), 1);
        chk("t1_c3_dat", 32'(inst_dat_o), 32'h2ABCD);
        chk("t1_c3_grant", 32'(grant_o), 1);
        chk("t1_c3_dack", 32'(data_ack_o), 0);
        set_inst(1'b0, 12'h000);
        step(1);
        chk("t1_c4_ack", 32'(inst_ack_o), 0);
        chk("t1_c4_grant", 32'(grant_o), 0);

        // data write 0x00055 to 0x0F0, then read back
        set_data(1'b1, 1'b1, 12'h0F0, 18'h00055);
        step(1);
        chk("t2w_c1_en", 32'(mem_en_o), 1);
        chk("t2w_c1_we", 32'(mem_we_o), 1);
        chk("t2w_c1_wdat", 32'(mem_dat_o), 32'h55);
        chk("t2w_c1_grant", 32'(grant_o), 2);
        step(2);
        chk("t2w_c3_ack", 32'(data_ack_o), 1);
        chk("t2w_c3_dat_hold", 32'(data_dat_o), 0);
        set_data(1'b0, 1'b0, 12'h000, 18'h0);
        step(1);
        set_data(1'b1, 1'b0, 12'h0F0, 18'h0);
        step(1);
        chk("t2r_c1_we", 32'(mem_we_o), 0);
        step(1);
        chk("t2r_c2_ack", 32'(data_ack_o), 0);
        step(1);
        chk("t2r_c3_ack", 32'(data_ack_o), 1);
        chk("t2r_c3_dat", 32'(data_dat_o), 32'h55);
        set_data(1'b0, 1'b0, 12'h000, 18'h0);
        step(1);

        // simultaneous requests after reset: data first, then inst
        rst_ni = 1'b0;
        step(2);
        rst_ni = 1'b1;
        step(1);
        set_inst(1'b1, 12'h020);
        set_data(1'b1, 1'b0, 12'h0F0, 18'h0);
        step(1);
        chk("t3_c1_grant", 32'(grant_o), 2);
        step(2);
        chk("t3_c3_dack", 32'(data_ack_o), 1);
        chk("t3_c3_iack", 32'(inst_ack_o), 0);
        chk("t3_c3_ddat", 32'(data_dat_o), 32'h55);
        set_data(1'b0, 1'b0, 12'h000, 18'h0);
        step(1);
        chk("t3_c4_grant", 32'(grant_o), 0);
        step(1);
        chk("t3_c5_en", 32'(mem_en_o), 1);
        chk("t3_c5_grant", 32'(grant_o), 1);
        chk("t3_c5_adr", 32'(mem_adr_o), 32'h020);
        step(1);
        chk("t3_c6_iack", 32'(inst_ack_o), 0);
        step(1);
        chk("t3_c7_iack", 32'(inst_ack_o), 1);
        chk("t3_c7_idat", 32'(inst_dat_o), 32'h12345);
        set_inst(1'b0, 12'h000);
        step(1);

        // continuous contention: D,I,D,I,D,I with 4-cycle ack spacing
        set_inst(1'b1, 12'h010);
        set_data(1'b1, 1'b0, 12'h0F0, 18'h0);
        for (int k = 0; k < 6; k++) begin
            step(k == 0 ? 2 : 3);
            chk("t4_pre_dack", 32'(data_ack_o), 0);
            chk("t4_pre_iack", 32'(inst_ack_o), 0);
            step(1);
            chk("t4_dack", 32'(data_ack_o), (k % 2 == 0) ? 1 : 0);
            chk("t4_iack", 32'(inst_ack_o), (k % 2 == 1) ? 1 : 0);
        end
        set_inst(1'b0, 12'h000);
        set_data(1'b0, 1'b0, 12'h000, 18'h0);
        chk("t4_idat", 32'(inst_dat_o), 32'h2ABCD);
        step(1);

        // inst drops stb mid-access
        set_inst(1'b1, 12'h020);
        step(2);
        set_inst(1'b0, 12'h000);
        step(1);
        chk("t5_c3_ack", 32'(inst_ack_o), 1);
        chk("t5_c3_dat", 32'(inst_dat_o), 32'h12345);
        step(1);
        chk("t5_c4_grant", 32'(grant_o), 0);
        chk("t5_c4_ack", 32'(inst_ack_o), 0);
        step(1);
        chk("t5_c5_en", 32'(mem_en_o), 0);
        chk("t5_c5_grant", 32'(grant_o), 0);

        // reset mid data read
        set_data(1'b1, 1'b0, 12'h0F0, 18'h0);
        step(2);
        rst_ni = 1'b0;
        set_data(1'b0, 1'b0, 12'h000, 18'h0);
        #1;
        chk("t6_rst_grant", 32'(grant_o), 0);
        chk("t6_rst_en", 32'(mem_en_o), 0);
        chk("t6_rst_we", 32'(mem_we_o), 0);
        chk("t6_rst_adr", 32'(mem_adr_o), 0);
        chk("t6_rst_idat", 32'(inst_dat_o), 0);
        chk("t6_rst_ddat", 32'(data_dat_o), 0);
        chk("t6_rst_dack", 32'(data_ack_o), 0);
        step(2);
        chk("t6_rst_noack", 32'(data_ack_o), 0);
        rst_ni = 1'b1;
        set_inst(1'b1, 12'h010);
        set_data(1'b1, 1'b0, 12'h0F0, 18'h0);
        step(1);
        chk("t6_c1_grant", 32'(grant_o), 2);
        step(2);
        chk("t6_c3_dack", 32'(data_ack_o), 1);
        chk("t6_c3_ddat", 32'(data_dat_o), 32'h55);
        set_inst(1'b0, 12'h000);
        set_data(1'b0, 1'b0, 12'h000, 18'h0);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
